// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. It sits beside the PC register of the pipelined MIPS core.
//   - IF side: lookup_pc is decoded combinationally, so the next fetch PC is
//     predicted in the same cycle (zero-latency read of a flop array).
//   - EX side: a resolved branch/jump trains the table on the rising clock
//     edge and, combinationally, reports whether the prediction it carried
//     down the pipe was wrong, together with the PC fetch must restart from.
//
// Address split (IDX_W = log2(ENTRIES)):
//   PC[1:0]                      ignored (word aligned)
//   PC[2 +: IDX_W]               entry index
//   PC[2+IDX_W +: TAG_W-1]       low tag bits
//   PC[ADDR_W-1]                 top tag bit, so kernel and user PCs never alias
//   Bits between the tag field and the MSB are not stored; PCs that differ
//   only there share an entry and hit on each other.
//
// Update protocol (EX side): there is no back-pressure. upd_valid qualifies
// upd_pc/upd_taken/upd_target/upd_pred_taken/upd_pred_target for exactly one
// cycle; the block always accepts it and commits on the next rising edge. A
// lookup to the same entry in that cycle still sees the old contents.
//
// Ports:
//   clk              core clock
//   reset            asynchronous, active-low reset
//   lookup_pc        PC currently being fetched
//   pred_hit         valid tag match for lookup_pc
//   pred_taken       pred_hit and counter MSB set
//   pred_next_pc     stored target when pred_taken, else lookup_pc+4
//   upd_valid        EX stage resolved a branch or jump this cycle
//   upd_pc           PC of the resolved instruction
//   upd_taken        actual outcome
//   upd_target       actual target when taken
//   upd_pred_taken   prediction carried with the instruction
//   upd_pred_target  predicted next PC carried with the instruction
//   mispredict       resolved branch was mispredicted (combinational)
//   redirect_pc      correct next PC: upd_taken ? upd_target : upd_pc+4
//   lookup_cnt       lookups performed (PERF_CNT_EN builds only, else 0)
//   mispred_cnt      mispredictions seen (PERF_CNT_EN builds only, else 0)
//
// Build option: define PERF_CNT_EN to build the two 32-bit saturating
// performance counters. Without it both ports read 0 and no flops exist.
//
// Parameter constraints: ENTRIES power of 2 and >= 4, TAG_W >= 2, CTR_W >= 1,
// ADDR_W large enough to hold 2 + IDX_W + TAG_W bits.
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 10,
  parameter int CTR_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_next_pc,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       lookup_cnt,
  output logic [31:0]       mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  // Counter encodings: weakly taken is MSB=1 rest 0, weakly not-taken is
  // MSB=0 rest 1 (i.e. one below weakly taken).
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_MIN = '0;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  // ---------------------------------------------------------------------------
  // Storage: one flop array per field.
  // ---------------------------------------------------------------------------
  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];

  // ---------------------------------------------------------------------------
  // Address decode for both ports.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;

  assign lk_idx = lookup_pc[2 +: IDX_W];
  assign lk_tag = {lookup_pc[ADDR_W-1], lookup_pc[2+IDX_W +: TAG_W-1]};
  assign up_idx = upd_pc[2 +: IDX_W];
  assign up_tag = {upd_pc[ADDR_W-1], upd_pc[2+IDX_W +: TAG_W-1]};

  // ---------------------------------------------------------------------------
  // Lookup (IF side): asynchronous read, sees pre-update contents.
  // ---------------------------------------------------------------------------
  logic              lk_valid;
  logic [TAG_W-1:0]  lk_stored_tag;
  logic [CTR_W-1:0]  lk_ctr;
  logic [ADDR_W-1:0] lk_target;

  assign lk_valid      = valid_q[lk_idx];
  assign lk_stored_tag = tag_q[lk_idx];
  assign lk_ctr        = ctr_q[lk_idx];
  assign lk_target     = target_q[lk_idx];

  // The reset term makes "no hit while reset is held" explicit rather than
  // relying only on the valid bits having been cleared.
  assign pred_hit     = reset && lk_valid && (lk_stored_tag == lk_tag);
  assign pred_taken   = pred_hit && lk_ctr[CTR_W-1];
  assign pred_next_pc = pred_taken ? lk_target : (lookup_pc + PC_STEP);

  // ---------------------------------------------------------------------------
  // Resolution (EX side): mispredict detection and redirect PC.
  // A taken branch is also wrong when the predicted target differs (e.g. a
  // stale BTB target for a register jump). Updates during reset are dropped,
  // so they never raise a redirect either.
  // ---------------------------------------------------------------------------
  logic dir_wrong;
  logic tgt_wrong;

  assign dir_wrong   = (upd_taken != upd_pred_taken);
  assign tgt_wrong   = upd_taken && (upd_target != upd_pred_target);
  assign mispredict  = upd_valid && reset && (dir_wrong || tgt_wrong);
  assign redirect_pc = upd_taken ? upd_target : (upd_pc + PC_STEP);

  // ---------------------------------------------------------------------------
  // Training: next-state of the addressed entry.
  // ---------------------------------------------------------------------------
  logic              up_hit;
  logic [CTR_W-1:0]  up_ctr;
  logic              wr_en;
  logic              wr_valid;
  logic [TAG_W-1:0]  wr_tag;
  logic [CTR_W-1:0]  wr_ctr;
  logic [ADDR_W-1:0] wr_target;

  assign up_ctr = ctr_q[up_idx];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    wr_en     = 1'b0;
    wr_valid  = valid_q[up_idx];
    wr_tag    = tag_q[up_idx];
    wr_ctr    = up_ctr;
    wr_target = target_q[up_idx];
    if (upd_valid) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (upd_taken) begin
          wr_ctr    = (up_ctr == CTR_MAX) ? CTR_MAX : (up_ctr + CTR_W'(1));
          wr_target = upd_target;
        end else begin
          wr_ctr    = (up_ctr == CTR_MIN) ? CTR_MIN : (up_ctr - CTR_W'(1));
        end
      end else if (upd_taken) begin
        // Allocate on a taken miss, evicting whatever held this index.
        wr_en     = 1'b1;
        wr_valid  = 1'b1;
        wr_tag    = up_tag;
        wr_ctr    = CTR_WT;
        wr_target = upd_target;
      end
      // A not-taken miss leaves the table alone: no point spending an entry
      // on a branch that falls through like sequential code.
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        ctr_q[i]    <= CTR_WNT;
        target_q[i] <= '0;
      end
    end else if (wr_en) begin
      valid_q[up_idx]  <= wr_valid;
      tag_q[up_idx]    <= wr_tag;
      ctr_q[up_idx]    <= wr_ctr;
      target_q[up_idx] <= wr_target;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters. Both saturate instead of wrapping so a long run
  // never reports a misleadingly small number. Reset clears them to 0.
  // ---------------------------------------------------------------------------
`ifdef PERF_CNT_EN
  logic [31:0] lookup_cnt_q;
  logic [31:0] mispred_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lookup_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (lookup_cnt_q != 32'hFFFF_FFFF) begin
        lookup_cnt_q <= lookup_cnt_q + 32'd1;
      end
      if (mispredict && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end
  end

  assign lookup_cnt  = lookup_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`else
  assign lookup_cnt  = 32'd0;
  assign mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Table of {inputs, expected outputs} records applied one per clock. Inputs
// are driven just after the rising edge; the expected record is pushed to a
// queue at drive time and popped at the falling edge, where the combinational
// outputs (reflecting all earlier updates) are compared. Hand-written
// sequences cover asynchronous reset mid-run and the performance counters.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] lookup_cnt;
  logic [31:0] mispred_cnt;

  branch_predictor dut (
    .clk             (clk),
    .reset           (reset),
    .lookup_pc       (lookup_pc),
    .pred_hit        (pred_hit),
    .pred_taken      (pred_taken),
    .pred_next_pc    (pred_next_pc),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .lookup_cnt      (lookup_cnt),
    .mispred_cnt     (mispred_cnt)
  );

  // ---------------------------------------------------------------------------
  // Clock / watchdog
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Vector records and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] lpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upt;
    logic [31:0] uptgt;
    logic        e_hit;
    logic        e_taken;
    logic [31:0] e_next;
    logic        e_mis;
    logic [31:0] e_redir;
  } vec_t;

  vec_t        vecs[$];
  logic [66:0] exp_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;

  function automatic vec_t mk(logic [31:0] lpc, logic uv, logic [31:0] upc,
                              logic ut, logic [31:0] utgt, logic upt,
                              logic [31:0] uptgt, logic e_hit, logic e_taken,
                              logic [31:0] e_next, logic e_mis,
                              logic [31:0] e_redir);
    vec_t v;
    v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.upt = upt; v.uptgt = uptgt; v.e_hit = e_hit; v.e_taken = e_taken;
    v.e_next = e_next; v.e_mis = e_mis; v.e_redir = e_redir;
    return v;
  endfunction

  // Lookup only; the idle update port (all zero) gives redirect 0+4.
  function automatic vec_t idle(logic [31:0] lpc, logic e_hit, logic e_taken,
                                logic [31:0] e_next);
    return mk(lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
              e_hit, e_taken, e_next, 1'b0, 32'h4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_idle();
    upd_valid       = 1'b0;
    upd_pc          = 32'h0;
    upd_taken       = 1'b0;
    upd_target      = 32'h0;
    upd_pred_taken  = 1'b0;
    upd_pred_target = 32'h0;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic t,
                           input logic [31:0] tgt, input logic pt,
                           input logic [31:0] ptgt);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = t;
    upd_target      = tgt;
    upd_pred_taken  = pt;
    upd_pred_target = ptgt;
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [66:0] e;
    @(posedge clk);
    #1;
    lookup_pc       = v.lpc;
    upd_valid       = v.uv;
    upd_pc          = v.upc;
    upd_taken       = v.ut;
    upd_target      = v.utgt;
    upd_pred_taken  = v.upt;
    upd_pred_target = v.uptgt;
    exp_q.push_back({v.e_hit, v.e_taken, v.e_next, v.e_mis, v.e_redir});
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL v%0d scoreboard: got empty queue expected one entry", idx);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("v%0d pred_hit", idx),     {31'h0, pred_hit},   {31'h0, e[66]});
      chk($sformatf("v%0d pred_taken", idx),   {31'h0, pred_taken}, {31'h0, e[65]});
      chk($sformatf("v%0d pred_next_pc", idx), pred_next_pc,        e[64:33]);
      chk($sformatf("v%0d mispredict", idx),   {31'h0, mispredict}, {31'h0, e[32]});
      chk($sformatf("v%0d redirect_pc", idx),  redirect_pc,         e[31:0]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test
  // ---------------------------------------------------------------------------
  logic [31:0] exp_lk_cnt;
  logic [31:0] exp_mp_cnt;

  initial begin
    // Vector table. Lookups see all updates from earlier rows, never the one
    // presented in the same row.
    // Cold miss, then allocation of 0x40 -> 0x100 (ctr becomes 10).
    vecs.push_back(idle(32'h40, 0, 0, 32'h44));
    vecs.push_back(mk(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0, 0, 32'h44, 1, 32'h100));
    vecs.push_back(idle(32'h40, 1, 1, 32'h100));
    // Not-taken training: 10 -> 01 -> 00 -> 00 -> 00.
    vecs.push_back(mk(32'h40, 1, 32'h40, 0, 32'h0, 1, 32'h100, 1, 1, 32'h100, 1, 32'h44));
    vecs.push_back(mk(32'h40, 1, 32'h40, 0, 32'h0, 1, 32'h100, 1, 0, 32'h44, 1, 32'h44));
    vecs.push_back(mk(32'h40, 1, 32'h40, 0, 32'h0, 0, 32'h44, 1, 0, 32'h44, 0, 32'h44));
    vecs.push_back(mk(32'h40, 1, 32'h40, 0, 32'h0, 0, 32'h44, 1, 0, 32'h44, 0, 32'h44));
    vecs.push_back(idle(32'h40, 1, 0, 32'h44));
    // Taken training up to saturation: 00 -> 01 -> 10 -> 11 -> 11, then 10.
    vecs.push_back(mk(32'h40, 1, 32'h40, 1, 32'h104, 0, 32'h44, 1, 0, 32'h44, 1, 32'h104));
    vecs.push_back(mk(32'h40, 1, 32'h40, 1, 32'h104, 0, 32'h44, 1, 0, 32'h44, 1, 32'h104));
    vecs.push_back(mk(32'h40, 1, 32'h40, 1, 32'h104, 1, 32'h104, 1, 1, 32'h104, 0, 32'h104));
    vecs.push_back(mk(32'h40, 1, 32'h40, 1, 32'h104, 1, 32'h104, 1, 1, 32'h104, 0, 32'h104));
    vecs.push_back(mk(32'h40, 1, 32'h40, 0, 32'h0, 1, 32'h104, 1, 1, 32'h104, 1, 32'h44));
    vecs.push_back(idle(32'h40, 1, 1, 32'h104));
    // Right direction, wrong target -> mispredict, target retrained (ctr 11).
    vecs.push_back(mk(32'h40, 1, 32'h40, 1, 32'h108, 1, 32'h104, 1, 1, 32'h104, 1, 32'h108));
    vecs.push_back(idle(32'h40, 1, 1, 32'h108));
    // Same-cycle lookup and update of 0x80.
    vecs.push_back(mk(32'h80, 1, 32'h80, 1, 32'h200, 0, 32'h84, 0, 0, 32'h84, 1, 32'h200));
    vecs.push_back(idle(32'h80, 1, 1, 32'h200));
    // Kernel PC does not alias the user entry.
    vecs.push_back(idle(32'h8000_0040, 0, 0, 32'h8000_0044));
    // Bit 20 lies above the tag field: aliases and hits.
    vecs.push_back(idle(32'h0010_0040, 1, 1, 32'h108));
    // Bit 8 is the lowest tag bit: same index, different tag, miss.
    vecs.push_back(idle(32'h0000_0140, 0, 0, 32'h144));
    // Not-taken miss at 0x140 must not evict 0x40.
    vecs.push_back(mk(32'h40, 1, 32'h140, 0, 32'h0, 0, 32'h144, 1, 1, 32'h108, 0, 32'h144));
    vecs.push_back(idle(32'h40, 1, 1, 32'h108));
    // PC+4 wraps modulo 2^32 on both sides.
    vecs.push_back(mk(32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0));
    // Kernel allocation evicts the user entry at the same index.
    vecs.push_back(mk(32'h8000_0040, 1, 32'h8000_0040, 1, 32'h300, 0, 32'h8000_0044,
                      0, 0, 32'h8000_0044, 1, 32'h300));
    vecs.push_back(idle(32'h8000_0040, 1, 1, 32'h300));
    vecs.push_back(idle(32'h40, 0, 0, 32'h44));
    // Mismatching fields but upd_valid=0: no mispredict; redirect still computed.
    vecs.push_back(mk(32'h40, 0, 32'h10, 1, 32'h500, 0, 32'h0, 0, 0, 32'h44, 0, 32'h500));

    // Reset block
    reset     = 1'b0;
    lookup_pc = 32'h40;
    drive_idle();
    #1;
    chk("reset pred_hit",     {31'h0, pred_hit},   32'h0);
    chk("reset pred_taken",   {31'h0, pred_taken}, 32'h0);
    chk("reset pred_next_pc", pred_next_pc,        32'h44);
    chk("reset lookup_cnt",   lookup_cnt,          32'h0);
    chk("reset mispred_cnt",  mispred_cnt,         32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) apply(vecs[i], i);

    // Asynchronous reset mid-run, away from any clock edge.
    @(negedge clk);
    #2;
    reset     = 1'b0;
    lookup_pc = 32'h80;
    drive_idle();
    #1;
    chk("midrst pred_hit 0x80",     {31'h0, pred_hit}, 32'h0);
    chk("midrst pred_next_pc 0x80", pred_next_pc,      32'h84);
    chk("midrst lookup_cnt",        lookup_cnt,        32'h0);
    chk("midrst mispred_cnt",       mispred_cnt,       32'h0);
    // An update presented across an edge while in reset is dropped.
    drive_upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    #1;
    chk("postrst pred_hit 0x80", {31'h0, pred_hit}, 32'h0);
    lookup_pc = 32'h8000_0040;
    #1;
    chk("postrst pred_hit 0x80000040", {31'h0, pred_hit}, 32'h0);

    // Ten cycles out of reset with two mispredicted updates.
    for (int i = 0; i < 10; i++) begin
      if (i == 3 || i == 7) drive_upd(32'h400, 1'b1, 32'h600, 1'b0, 32'h404);
      else                  drive_idle();
      @(posedge clk);
      #1;
    end
    drive_idle();
`ifdef PERF_CNT_EN
    exp_lk_cnt = 32'd10;
    exp_mp_cnt = 32'd2;
`else
    exp_lk_cnt = 32'd0;
    exp_mp_cnt = 32'd0;
`endif
    chk("perf lookup_cnt",  lookup_cnt,  exp_lk_cnt);
    chk("perf mispred_cnt", mispred_cnt, exp_mp_cnt);
    // The trained 0x400 entry exists, then reset clears counters and entries.
    lookup_pc = 32'h400;
    #1;
    chk("perf trained hit 0x400", {31'h0, pred_hit}, 32'h1);
    reset = 1'b0;
    #1;
    chk("perf reset lookup_cnt",  lookup_cnt,          32'h0);
    chk("perf reset mispred_cnt", mispred_cnt,         32'h0);
    chk("perf reset hit 0x400",   {31'h0, pred_hit},   32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("perf after reset hit 0x400", {31'h0, pred_hit}, 32'h0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised branch target buffer (BTB) with saturating direction counters for the pipelined MIPS core.
- Generalises the current fixed resolve-in-EX, flush-on-taken scheme: IF predicts next PC in the same cycle; EX resolves and trains the predictor.
- On a wrong prediction the block returns a mispredict flag and the redirect PC.
- Sits beside the PC register; lookup is driven from PC, update from the EX stage.

Parameters:
ADDR_W, 32, PC width in bits.
ENTRIES, 64, BTB entries; must be a power of 2, minimum 4.
TAG_W, 10, tag bits taken from PC above the index field; includes PC[31] so kernel and user code never alias.
CTR_W, 2, width of the saturating direction counter, minimum 1.

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
lookup_pc  in  ADDR_W  PC currently being fetched
pred_hit  out  1  valid tag match for lookup_pc
pred_taken  out  1  predicted taken (hit and counter MSB set)
pred_next_pc  out  ADDR_W  pred_taken ? stored target : lookup_pc+4
upd_valid  in  1  EX stage has resolved a branch or jump this cycle
upd_pc  in  ADDR_W  PC of the resolved instruction
upd_taken  in  1  actual outcome
upd_target  in  ADDR_W  actual target when taken
upd_pred_taken  in  1  prediction carried down the pipe with the instruction
upd_pred_target  in  ADDR_W  predicted next PC carried down the pipe
mispredict  out  1  combinational flag: the resolved branch was mispredicted
redirect_pc  out  ADDR_W  correct next PC: upd_taken ? upd_target : upd_pc+4
lookup_cnt  out  32  lookups performed (optional feature)
mispred_cnt  out  32  mispredictions seen (optional feature)

Behaviour:
- Index = PC[2 +: log2(ENTRIES)]. Tag = next TAG_W-1 bits above the index field, concatenated with PC[31]. PC[1:0] is ignored.
- Storage per entry: valid, tag, counter, target, held in a flop array.
- Lookup: asynchronous read, zero latency.
  - pred_hit = valid and tag equal.
  - pred_taken = pred_hit and ctr[CTR_W-1].
- mispredict = upd_valid and (upd_taken != upd_pred_taken, or upd_taken and upd_target != upd_pred_target). It is 0 when upd_valid=0.
- Update is written on the clk rising edge when upd_valid=1:
  - Hit, taken: counter += 1, saturating at all-ones; target <= upd_target.
  - Hit, not taken: counter -= 1, saturating at 0; target unchanged.
  - Miss, taken: allocate the entry (overwrite). valid=1, tag, target, counter = weakly taken (MSB=1, rest 0).
  - Miss, not taken: no change.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. The new value is visible from the next cycle.
- Reset (reset=0), asynchronous, including mid-operation:
  - All valid bits cleared; counters set to weakly not-taken (MSB=0, rest 1); targets set to 0.
  - Outputs during reset: pred_hit=0, pred_taken=0, pred_next_pc=lookup_pc+4.
  - Counters cleared to 0.
  - Updates presented while reset=0 are dropped.
- PC+4 arithmetic is modulo 2^ADDR_W; 0xFFFFFFFC+4 = 0.
- Index/tag boundary checks:
  - PCs differing only above the tag field alias to the same entry and are treated as a hit.
  - PCs differing only in PC[31] never hit each other's entry.

Optional Feature:
PERF_CNT_EN
- Defined: lookup_cnt increments every cycle out of reset. mispred_cnt increments on each cycle with mispredict=1. Both are 32-bit and saturate at 0xFFFFFFFF.
- Undefined: both ports are tied to 0 and no counter flops are built.
- Ports are present in both builds.

Test Plan:
- Reset, then lookup 0x00000040 -> pred_hit=0, pred_taken=0, pred_next_pc=0x00000044.
- Update pc=0x40, taken, target=0x100, pred_taken=0 -> mispredict=1, redirect_pc=0x100. Next cycle lookup 0x40 -> hit=1, taken=1, next_pc=0x100.
- Three not-taken updates at 0x40 (CTR_W=2) -> counter saturates at 0. Lookup gives taken=0, next_pc=0x44. A fourth not-taken with pred_taken=0 -> mispredict=0.
- Lookup and update of 0x80 (taken, target 0x200) in the same cycle -> that cycle hit=0. Following cycle hit=1, next_pc=0x200.
- Train 0x00000040 taken to 0x100, then look up 0x80000040 -> hit=0; kernel PC does not alias the user entry.
- With PERF_CNT_EN: 10 cycles out of reset with 2 mispredicts -> lookup_cnt=10, mispred_cnt=2. Assert reset mid-run -> both 0 and all entries invalid.
